// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sevenseg_scan_driver                                              |
// | Desc   : 4-digit common-anode 7-seg scanner with per-slot anode dead time  |
// |          and frame-aligned data updates. Option: SEVENSEG_LZ_BLANK_EN     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_sync,
  output logic        busy_pending
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          w_tick;
  logic          w_wrap;

  logic [15:0]   r_data_act;
  logic [3:0]    r_dp_act;
  logic [3:0]    r_en_act;
  logic [15:0]   r_data_pend;
  logic [3:0]    r_dp_pend;
  logic [3:0]    r_en_pend;
  logic          r_pend_vld;

  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_sync;

  logic [3:0]    w_lz_keep;
  logic [3:0]    w_nib;
  logic          w_show;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  assign w_tick = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_state <= ST_GUARD;
    end else begin
      r_state <= w_state_nxt;
      if (w_tick) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // GUARD occupies slot counts 0..GUARD_CYCLES-1, ON the remainder.
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      w_state_nxt = ST_GUARD;
    end else if (r_state == ST_GUARD && r_cnt == CW'(GUARD_CYCLES - 1)) begin
      w_state_nxt = ST_ON;
    end
  end

  // A load coinciding with the frame wrap bypasses the pending register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_act  <= 16'h0000;
      r_dp_act    <= 4'b0000;
      r_en_act    <= 4'b1111;
      r_data_pend <= 16'h0000;
      r_dp_pend   <= 4'b0000;
      r_en_pend   <= 4'b0000;
      r_pend_vld  <= 1'b0;
    end else if (w_wrap && load) begin
      r_data_act <= data_in;
      r_dp_act   <= dp_in;
      r_en_act   <= digit_en;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_wrap && r_pend_vld) begin
        r_data_act <= r_data_pend;
        r_dp_act   <= r_dp_pend;
        r_en_act   <= r_en_pend;
        r_pend_vld <= 1'b0;
      end
      if (load) begin
        r_data_pend <= data_in;
        r_dp_pend   <= dp_in;
        r_en_pend   <= digit_en;
        r_pend_vld  <= 1'b1;
      end
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  assign w_lz_keep = {|r_data_act[15:12], |r_data_act[15:8], |r_data_act[15:4], 1'b1};
`else
  assign w_lz_keep = 4'b1111;
`endif

  assign w_nib  = r_data_act[{r_idx, 2'b00} +: 4];
  assign w_show = r_en_act[r_idx] & w_lz_keep[r_idx];

  always_comb begin
    w_an_nxt = 4'b1111;
    if (r_state == ST_ON && w_show && !blank) begin
      w_an_nxt = ~(4'b0001 << r_idx);
    end
    w_dp_nxt = ~(r_dp_act[r_idx] & w_lz_keep[r_idx]);
    case (w_nib)
      4'h0:    w_seg_nxt = 7'b1000000;
      4'h1:    w_seg_nxt = 7'b1111001;
      4'h2:    w_seg_nxt = 7'b0100100;
      4'h3:    w_seg_nxt = 7'b0110000;
      4'h4:    w_seg_nxt = 7'b0011001;
      4'h5:    w_seg_nxt = 7'b0010010;
      4'h6:    w_seg_nxt = 7'b0000010;
      4'h7:    w_seg_nxt = 7'b1111000;
      4'h8:    w_seg_nxt = 7'b0000000;
      4'h9:    w_seg_nxt = 7'b0010000;
      4'hA:    w_seg_nxt = 7'b0001000;
      4'hB:    w_seg_nxt = 7'b0000011;
      4'hC:    w_seg_nxt = 7'b1000110;
      4'hD:    w_seg_nxt = 7'b0100001;
      4'hE:    w_seg_nxt = 7'b0000110;
      default: w_seg_nxt = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= 4'b1111;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_frame_sync <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_sync <= w_wrap;
    end
  end

  assign an           = r_an;
  assign seg          = r_seg;
  assign dp           = r_dp;
  assign frame_sync   = r_frame_sync;
  assign busy_pending = r_pend_vld;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_sevenseg_scan_driver                                           |
// | Desc   : Scoreboard bench for sevenseg_scan_driver (time-based model)      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sevenseg_scan_driver;

  localparam int R = 8;
  localparam int G = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_sync;
  logic        busy_pending;

  sevenseg_scan_driver #(.REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .digit_en(digit_en),
    .load(load), .blank(blank), .an(an), .seg(seg), .dp(dp),
    .frame_sync(frame_sync), .busy_pending(busy_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       bp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: display time t counted in clocks since reset release.
  int          t = 0;
  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_en = 4'hF;
  logic        m_pv = 1'b0;
  logic [15:0] p_data = 16'h0;
  logic [3:0]  p_dp = 4'h0;
  logic [3:0]  p_en = 4'h0;

  logic [6:0] seg_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic bit lz_keep(input logic [15:0] d, input int idx);
`ifdef SEVENSEG_LZ_BLANK_EN
    if (idx == 0) return 1'b1;
    return (d >> (idx * 4)) != 16'h0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void model_edge();
    exp_t e;
    int   pos;
    int   idx;
    bit   lit;
    bit   wrap;
    if (rst) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0; e.bp = 1'b0;
      t = 0; m_data = 16'h0; m_dp = 4'h0; m_en = 4'hF; m_pv = 1'b0;
    end else begin
      pos  = t % R;
      idx  = (t / R) % 4;
      lit  = (pos >= G) && m_en[idx] && lz_keep(m_data, idx) && !blank;
      for (int i = 0; i < 4; i++) e.an[i] = !(lit && i == idx);
      e.seg = seg_lut[m_data[idx*4 +: 4]];
      e.dp  = !(m_dp[idx] && lz_keep(m_data, idx));
      wrap  = (pos == R - 1) && (idx == 3);
      e.fs  = wrap;
      if (wrap && load) begin
        m_data = data_in; m_dp = dp_in; m_en = digit_en; m_pv = 1'b0;
      end else begin
        if (wrap && m_pv) begin
          m_data = p_data; m_dp = p_dp; m_en = p_en; m_pv = 1'b0;
        end
        if (load) begin
          p_data = data_in; p_dp = dp_in; p_en = digit_en; m_pv = 1'b1;
        end
      end
      e.bp = m_pv;
      t++;
    end
    q.push_back(e);
  endfunction

  function automatic void chk(input string name, input logic [6:0] act, input logic [6:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an", {3'b0, an}, {3'b0, e.an});
      chk("seg", seg, e.seg);
      chk("dp", {6'b0, dp}, {6'b0, e.dp});
      chk("frame_sync", {6'b0, frame_sync}, {6'b0, e.fs});
      chk("busy_pending", {6'b0, busy_pending}, {6'b0, e.bp});
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Advance until the next edge will process slot index idx at position pos.
  task automatic go_to(input int idx, input int pos);
    for (int k = 0; k < 4 * R + 1; k++) begin
      if ((t % R) == pos && ((t / R) % 4) == idx) return;
      step();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
    data_in = d; dp_in = p; digit_en = en; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (70) step();

    go_to(1, 3);
    do_load(16'h12AF, 4'h0, 4'hF);
    repeat (80) step();

    go_to(3, R - 1);
    do_load(16'h5A3C, 4'h8, 4'hF);
    repeat (40) step();

    go_to(0, 4);
    do_load(16'h9876, 4'b0001, 4'b0101);
    repeat (80) step();

    go_to(2, G + 1);
    blank = 1'b1;
    repeat (5) step();
    blank = 1'b0;
    repeat (40) step();

    go_to(1, 1);
    do_load(16'hDEAD, 4'hF, 4'hF);
    repeat (3) step();
    do_load(16'hBEEF, 4'h2, 4'b1011);
    repeat (70) step();

    go_to(0, 0);
    do_load(16'h0000, 4'hF, 4'hF);
    repeat (70) step();
    do_load(16'h0040, 4'hF, 4'hF);
    repeat (70) step();

    for (int k = 0; k < 600; k++) begin
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        data_in  = 16'($urandom());
        dp_in    = 4'($urandom());
        digit_en = 4'($urandom());
      end
      if ($urandom_range(0, 11) == 0) blank = ~blank;
      step();
    end
    load = 1'b0; blank = 1'b0;

    go_to(1, 4);
    do_load(16'h4321, 4'h3, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (70) step();

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d entries left required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
